tron_round_ctrl: RTL

// - Round/score sequencer for the two-player Tron game; sits between kbInput, the trail datapath and the VGA pixel path.
// - Generates the trail move tick, clears trails at round start and samples per-pixel collision flags across each frame.
// - Decides crash/draw at frame end, keeps scores and sequences the IDLE/countdown/run/crash/game-over flow.

---
 rtl/tron_round_ctrl_if.sv | 25 ++
 rtl/tron_round_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/tron_round_ctrl_if.sv
// tron_round_ctrl_if: control/pixel-flag bundle between the round sequencer and its neighbours
interface tron_round_ctrl_if #(parameter int SCORE_W = 4);
    logic               start;
    logic               frame_start;
    logic               frame_end;
    logic               head1;
    logic               head2;
    logic               lethal;
    logic               clear_trails;
    logic               move_tick;
    logic [2:0]         state;
    logic               crash1;
    logic               crash2;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               game_over;
    modport master (
        output start, frame_start, frame_end, head1, head2, lethal,
        input  clear_trails, move_tick, state, crash1, crash2, score1, score2, game_over
    );
    modport slave (
        input  start, frame_start, frame_end, head1, head2, lethal,
        output clear_trails, move_tick, state, crash1, crash2, score1, score2, game_over
    );
endinterface

// File: rtl/tron_round_ctrl.sv
// tron_round_ctrl: Tron round/score sequencer; define TRON_PAUSE_EN to add the RUN<->PAUSE toggle on start
module tron_round_ctrl #(
    parameter int TICK_DIV    = 1777777,
    parameter int COUNT_TICKS = 3,
    parameter int HOLD_FRAMES = 60,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input logic              clk,
    input logic              reset,
    tron_round_ctrl_if.slave bus
);
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int CNT_W = $clog2(COUNT_TICKS + 2);
    localparam int FRM_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(COUNT_TICKS);
    localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        COUNT = 3'd2,
        RUN   = 3'd3,
        CRASH = 3'd4,
        OVER  = 3'd5,
        PAUSE = 3'd6
    } state_t;

    state_t             st, nxt;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   cnt;
    logic [FRM_W-1:0]   frm;
    logic               h1l, h2l, hh;
    logic               crash1_r, crash2_r;
    logic [SCORE_W-1:0] s1, s2;
    logic               wrap, c1, c2, crash, live;

    assign wrap  = div == DIV_MAX;
    assign c1    = h1l | hh;
    assign c2    = h2l | hh;
    assign crash = st == RUN && bus.frame_end && (c1 | c2);
    assign live  = st == RUN || st == PAUSE;

    // state register
    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= nxt;
    end

    // next-state: round flow, start only honoured where it has a meaning
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = bus.start ? CLEAR : IDLE;
            CLEAR:   nxt = COUNT;
            COUNT:   nxt = cnt == '0 ? RUN : COUNT;
`ifdef TRON_PAUSE_EN
            RUN:     nxt = crash ? CRASH : bus.start ? PAUSE : RUN;
            PAUSE:   nxt = bus.start ? RUN : PAUSE;
`else
            RUN:     nxt = crash ? CRASH : RUN;
`endif
            CRASH:   nxt = bus.frame_end && frm == FRM_LAST ? ((s1 == WIN || s2 == WIN) ? OVER : CLEAR) : CRASH;
            OVER:    nxt = bus.start ? CLEAR : OVER;
            default: nxt = IDLE;
        endcase
    end

    // divider, countdown, hold-frame counter, per-frame collision flags, crash latches and scores
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            cnt      <= '0;
            frm      <= '0;
            h1l      <= 1'b0;
            h2l      <= 1'b0;
            hh       <= 1'b0;
            crash1_r <= 1'b0;
            crash2_r <= 1'b0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            div      <= (st == COUNT && cnt != '0) || st == RUN ? (wrap ? '0 : div + 1'b1) : st == PAUSE ? div : '0;
            cnt      <= st == CLEAR ? CNT_INIT : (st == COUNT && wrap && cnt != '0) ? cnt - 1'b1 : cnt;
            frm      <= st == CRASH ? frm + FRM_W'(bus.frame_end) : '0;
            h1l      <= live && ((h1l && !bus.frame_start) || (bus.head1 && bus.lethal));
            h2l      <= live && ((h2l && !bus.frame_start) || (bus.head2 && bus.lethal));
            hh       <= live && ((hh && !bus.frame_start) || (bus.head1 && bus.head2));
            crash1_r <= st == CLEAR ? 1'b0 : crash ? c1 : crash1_r;
            crash2_r <= st == CLEAR ? 1'b0 : crash ? c2 : crash2_r;
            s1       <= st == OVER && bus.start ? '0 : (crash && c2 && !c1 && s1 != WIN) ? s1 + 1'b1 : s1;
            s2       <= st == OVER && bus.start ? '0 : (crash && c1 && !c2 && s2 != WIN) ? s2 + 1'b1 : s2;
        end
    end

    // outputs decoded from state and registers
    always_comb begin
        bus.clear_trails = st == CLEAR;
        bus.move_tick    = st == RUN && wrap;
        bus.game_over    = st == OVER;
        bus.state        = st;
        bus.crash1       = crash1_r;
        bus.crash2       = crash2_r;
        bus.score1       = s1;
        bus.score2       = s2;
    end
endmodule
